// File: rtl/sys_array_host_pkg.sv
// Shared types and sizing helpers for the sys_array_host initiator.
package sys_array_host_pkg;

  // Host sequencing states, in the order a transaction visits them.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_W = 3'd2,
    S_LOAD   = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    S_DRAIN  = 3'd6
  } host_state_t;

  // Element counts of the A, W and result matrices.
  function automatic int a_elems(int a_w, int a_l);
    return a_w * a_l;
  endfunction

  function automatic int w_elems(int w_w, int w_l);
    return w_w * w_l;
  endfunction

  function automatic int c_elems(int a_w, int w_l);
    return a_w * w_l;
  endfunction

  // Width of an index that must address n entries (at least one bit).
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sys_array_host_result_drainer.sv
// sys_array_result_drainer: holds the captured result matrix and streams it
// out row-major under a valid/ready handshake. A beat moves only when
// m_valid && m_ready; m_data/m_last are held while m_valid && !m_ready.
module sys_array_result_drainer
  import sys_array_host_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int RES_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 capture,
  input  logic [0:ROWS-1][0:COLS-1][RES_W-1:0] capture_data,
  output logic [RES_W-1:0]                     m_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic                                 m_last,
  output logic                                 done
);

  localparam int RW = idx_width(ROWS);
  localparam int CW = idx_width(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [0:ROWS-1][0:COLS-1][RES_W-1:0] result;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          at_last;

  assign at_last = (row == ROW_LAST) && (col == COL_LAST);
  assign m_data  = result[row][col];
  assign m_last  = m_valid && at_last;
  assign done    = m_valid && m_ready && at_last;

  // Capture the result matrix, then step the output index per handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      m_valid <= 1'b0;
      row     <= '0;
      col     <= '0;
    end else if (capture) begin
      result  <= capture_data;
      m_valid <= 1'b1;
      row     <= '0;
      col     <= '0;
    end else if (m_valid && m_ready) begin
      if (at_last) begin
        m_valid <= 1'b0;
        row     <= '0;
        col     <= '0;
      end else if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_array_host.sv
// sys_array_host: serial-to-parallel initiator for sys_array_fetcher.
// Loads A then W element by element (s_valid/s_ready), pulses load_params
// and start_comp, waits for the fetcher's ready and drains the result.
// Optional watchdog in WAIT is enabled by defining SYS_HOST_TIMEOUT_EN.
// Handshakes: a beat transfers on a rising clk edge where valid && ready;
// valid-side data must stay stable until that edge.
module sys_array_host
  import sys_array_host_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ARRAY_A_W      = 4,
  parameter int ARRAY_A_L      = 3,
  parameter int ARRAY_W_W      = 3,
  parameter int ARRAY_W_L      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [DATA_WIDTH-1:0]                                 s_data,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  output logic [2*DATA_WIDTH-1:0]                               m_data,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic                                                  m_last,
  output logic                                                  load_params,
  output logic                                                  start_comp,
  output logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]   input_data_a,
  output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]   input_data_w,
  input  logic                                                  ready,
  input  logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0] out_data,
  output logic                                                  busy,
  output logic                                                  timeout_err
);

  localparam int RW = idx_width(max2(ARRAY_A_W, ARRAY_W_W));
  localparam int CW = idx_width(max2(ARRAY_A_L, ARRAY_W_L));
  localparam logic [RW-1:0] A_ROW_LAST = RW'(ARRAY_A_W - 1);
  localparam logic [CW-1:0] A_COL_LAST = CW'(ARRAY_A_L - 1);
  localparam logic [RW-1:0] W_ROW_LAST = RW'(ARRAY_W_W - 1);
  localparam logic [CW-1:0] W_COL_LAST = CW'(ARRAY_W_L - 1);

  if (ARRAY_A_L != ARRAY_W_W) begin : g_bad_inner_dim
    $error("sys_array_host: ARRAY_A_L must equal ARRAY_W_W");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sys_array_host: TIMEOUT_CYCLES must be at least 2");
  end

  host_state_t   state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          guard;
  logic          capture;
  logic          drain_done;

  // ready is honoured only after the first WAIT cycle, so a level left
  // over from the previous computation is never mistaken for completion.
  assign capture = (state == S_WAIT) && !guard && ready;

`ifdef SYS_HOST_TIMEOUT_EN
  localparam int TW = idx_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // Main sequencer: operand loading, fetcher pulses, completion wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      s_ready      <= 1'b0;
      load_params  <= 1'b0;
      start_comp   <= 1'b0;
      busy         <= 1'b0;
      row          <= '0;
      col          <= '0;
      guard        <= 1'b0;
      input_data_a <= '0;
      input_data_w <= '0;
`ifdef SYS_HOST_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      load_params <= 1'b0;
      start_comp  <= 1'b0;
      case (state)
        S_IDLE: begin
          state   <= S_LOAD_A;
          s_ready <= 1'b1;
        end
        S_LOAD_A: begin
          if (s_valid && s_ready) begin
            input_data_a[row][col] <= s_data;
            if (col == A_COL_LAST) begin
              col <= '0;
              if (row == A_ROW_LAST) begin
                row   <= '0;
                state <= S_LOAD_W;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (s_valid && s_ready) begin
            input_data_w[row][col] <= s_data;
            if (col == W_COL_LAST) begin
              col <= '0;
              if (row == W_ROW_LAST) begin
                row         <= '0;
                state       <= S_LOAD;
                s_ready     <= 1'b0;
                busy        <= 1'b1;
                load_params <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_LOAD: begin
          state      <= S_START;
          start_comp <= 1'b1;
        end
        S_START: begin
          state <= S_WAIT;
          guard <= 1'b1;
`ifdef SYS_HOST_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          guard <= 1'b0;
          if (capture) begin
            state <= S_DRAIN;
          end
`ifdef SYS_HOST_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_LOAD_A;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          if (drain_done) begin
            state   <= S_LOAD_A;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  sys_array_result_drainer #(
    .ROWS  (ARRAY_A_W),
    .COLS  (ARRAY_W_L),
    .RES_W (2*DATA_WIDTH)
  ) u_drainer (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .capture_data (out_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .done         (drain_done)
  );

endmodule

// File: tb/tb_sys_array_host.sv
// Testbench for sys_array_host with a behavioural fetcher model.
// Builds with or without SYS_HOST_TIMEOUT_EN; the watchdog scenario runs
// only when it is defined (TIMEOUT_CYCLES is set to 16 here).
module tb_sys_array_host;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int AL = 3;
  localparam int WW = 3;
  localparam int WL = 4;
  localparam int TO = 16;
  localparam int NA = AW * AL;
  localparam int NW = WW * WL;
  localparam int NC = AW * WL;
  localparam int NB = NA + NW;

  logic                                 clk = 1'b0;
  logic                                 reset = 1'b1;
  logic [DW-1:0]                        s_data;
  logic                                 s_valid;
  logic                                 s_ready;
  logic [2*DW-1:0]                      m_data;
  logic                                 m_valid;
  logic                                 m_ready;
  logic                                 m_last;
  logic                                 load_params;
  logic                                 start_comp;
  logic [0:AW-1][0:AL-1][DW-1:0]        input_data_a;
  logic [0:WW-1][0:WL-1][DW-1:0]        input_data_w;
  logic                                 ready;
  logic [0:AW-1][0:WL-1][2*DW-1:0]      out_data;
  logic                                 busy;
  logic                                 timeout_err;

  sys_array_host #(
    .DATA_WIDTH(DW), .ARRAY_A_W(AW), .ARRAY_A_L(AL),
    .ARRAY_W_W(WW), .ARRAY_W_L(WL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .load_params(load_params),
    .start_comp(start_comp), .input_data_a(input_data_a),
    .input_data_w(input_data_w), .ready(ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Clock
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Stimulus / logging state
  logic [DW-1:0]   in_q[$];
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] got_q[$];
  bit              got_last_q[$];
  int acc_cyc_q[$], lastw_q[$], lp_q[$], sc_q[$], mv_q[$], mlast_q[$], to_q[$];
  int acc_total = 0;
  int stall_bad = 0;
  int mv_busy_bad = 0;
  bit to_sready = 1'b0;
  bit gap_mode = 1'b0;
  bit gap_phase = 1'b0;
  bit rand_ready = 1'b0;
  int fetch_lat = 0;
  bit fetch_hold = 1'b0;
  logic [DW-1:0] a_m[AW][AL];
  logic [DW-1:0] w_m[WW][WL];
  int dir_exp[NC] = '{1, 2, 3, 0, 4, 5, 6, 0, 7, 8, 9, 0, 10, 11, 12, 0};

  // Stream driver: presents the head of in_q; the monitor pops on handshake
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (in_q.size() > 0 && !(gap_mode && gap_phase)) begin
        s_valid = 1'b1;
        s_data  = in_q[0];
      end else begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
      end
      gap_phase = ~gap_phase;
    end
  end

  // Downstream ready driver
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Fetcher model: on start_comp computes A*W from the buses it was given
  // and raises ready fetch_lat cycles later; load_params drops ready.
  initial begin
    int fcnt;
    logic [2*DW-1:0] acc;
    fcnt = -1;
    ready = 1'b0;
    out_data = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        ready = 1'b0;
        fcnt = -1;
      end else begin
        if (load_params) ready = 1'b0;
        if (start_comp && !fetch_hold) begin
          for (int i = 0; i < AW; i++)
            for (int j = 0; j < WL; j++) begin
              acc = '0;
              for (int k = 0; k < AL; k++)
                acc += (2*DW)'(input_data_a[i][k]) * (2*DW)'(input_data_w[k][j]);
              out_data[i][j] = acc;
            end
          fcnt = fetch_lat;
        end
        if (fcnt == 0) begin
          ready = 1'b1;
          fcnt = -1;
        end else if (fcnt > 0) begin
          fcnt--;
        end
      end
    end
  end

  // Monitor: samples mid-cycle, logs handshakes and event cycles
  bit              prev_mv = 1'b0;
  bit              prev_stall = 1'b0;
  bit              prev_to = 1'b0;
  logic [2*DW-1:0] prev_data = '0;
  logic            prev_last = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (s_valid && s_ready) begin
        acc_cyc_q.push_back(cyc);
        acc_total++;
        if (in_q.size() > 0) void'(in_q.pop_front());
        if (acc_total % NB == 0) lastw_q.push_back(cyc);
      end
      if (load_params) lp_q.push_back(cyc);
      if (start_comp) sc_q.push_back(cyc);
      if (m_valid && !prev_mv) begin
        mv_q.push_back(cyc);
        if (!busy) mv_busy_bad++;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        stall_bad++;
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_last_q.push_back(m_last);
        if (m_last) mlast_q.push_back(cyc);
      end
      if (timeout_err && !prev_to) begin
        to_q.push_back(cyc);
        to_sready = s_ready;
      end
    end
    prev_mv    = m_valid;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    prev_to    = timeout_err;
  end

  task automatic clear_logs();
    exp_q.delete(); got_q.delete(); got_last_q.delete(); acc_cyc_q.delete();
    lastw_q.delete(); lp_q.delete(); sc_q.delete(); mv_q.delete();
    mlast_q.delete(); to_q.delete();
    acc_total = 0;
    stall_bad = 0;
    mv_busy_bad = 0;
  endtask

  task automatic set_directed();
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) a_m[r][c] = DW'(r * AL + c + 1);
    for (int r = 0; r < WW; r++)
      for (int c = 0; c < WL; c++) w_m[r][c] = (r == c) ? 8'd1 : 8'd0;
  endtask

  task automatic set_random();
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) a_m[r][c] = DW'($urandom);
    for (int r = 0; r < WW; r++)
      for (int c = 0; c < WL; c++) w_m[r][c] = DW'($urandom);
  endtask

  // Queue the operand beats (A row-major then W row-major)
  task automatic push_operands();
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) in_q.push_back(a_m[r][c]);
    for (int r = 0; r < WW; r++)
      for (int c = 0; c < WL; c++) in_q.push_back(w_m[r][c]);
  endtask

  // Reference: matrix product of the bench's own operands, row-major
  task automatic push_expected_product();
    int sum;
    for (int i = 0; i < AW; i++)
      for (int j = 0; j < WL; j++) begin
        sum = 0;
        for (int k = 0; k < AL; k++) sum += int'(a_m[i][k]) * int'(w_m[k][j]);
        exp_q.push_back((2*DW)'(sum));
      end
  endtask

  task automatic wait_mlast(input int n, input string tag);
    int budget;
    budget = 3000;
    while (mlast_q.size() < n && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (mlast_q.size() < n) begin
      total_cnt++;
      $display("FAIL %s_timeout: m_last handshakes seen %0d, required %0d", tag, mlast_q.size(), n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Compares drained stream, m_last placement and operand buses
  task automatic drain_and_compare(input string tag);
    logic [0:AW-1][0:AL-1][DW-1:0] ea;
    logic [0:WW-1][0:WL-1][DW-1:0] ew;
    total_cnt++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s_count: got %0d results, required %0d", tag, got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_data[%0d]: got %0d, required %0d", tag, i, got_q[i], exp_q[i]);
      else pass_cnt++;
      total_cnt++;
      if (got_last_q[i] !== ((i % NC) == NC - 1))
        $display("FAIL %s_last[%0d]: got %0b, required %0b", tag, i, got_last_q[i], (i % NC) == NC - 1);
      else pass_cnt++;
    end
    for (int r = 0; r < AW; r++)
      for (int c = 0; c < AL; c++) ea[r][c] = a_m[r][c];
    for (int r = 0; r < WW; r++)
      for (int c = 0; c < WL; c++) ew[r][c] = w_m[r][c];
    total_cnt++;
    if (input_data_a !== ea) $display("FAIL %s_bus_a: got %h, required %h", tag, input_data_a, ea);
    else pass_cnt++;
    total_cnt++;
    if (input_data_w !== ew) $display("FAIL %s_bus_w: got %h, required %h", tag, input_data_w, ew);
    else pass_cnt++;
    total_cnt++;
    if (mv_busy_bad !== 0) $display("FAIL %s_busy: m_valid without busy %0d times, required 0", tag, mv_busy_bad);
    else pass_cnt++;
  endtask

  task automatic check_pulse_timing(input string tag);
    int n, cap;
    n = lastw_q[0];
    cap = (n + 4 > n + 2 + fetch_lat) ? n + 4 : n + 2 + fetch_lat;
    total_cnt++;
    if (lp_q.size() !== 1 || lp_q[0] !== n + 1)
      $display("FAIL %s_load_params: at cycle %0d (count %0d), required %0d", tag, lp_q[0], lp_q.size(), n + 1);
    else pass_cnt++;
    total_cnt++;
    if (sc_q.size() !== 1 || sc_q[0] !== n + 2)
      $display("FAIL %s_start_comp: at cycle %0d (count %0d), required %0d", tag, sc_q[0], sc_q.size(), n + 2);
    else pass_cnt++;
    total_cnt++;
    if (mv_q[0] !== cap + 1)
      $display("FAIL %s_m_valid_rise: at cycle %0d, required %0d", tag, mv_q[0], cap + 1);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({s_ready, m_valid, m_last, load_params, start_comp, busy, timeout_err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {s_ready, m_valid, m_last, load_params, start_comp, busy, timeout_err});
    else pass_cnt++;
    total_cnt++;
    if (input_data_a !== '0 || input_data_w !== '0 || m_data !== '0)
      $display("FAIL reset_data: got a=%h w=%h m=%h, required 0", input_data_a, input_data_w, m_data);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (s_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: got s_ready=%b busy=%b, required 1 0", s_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_directed(input bit gap, input string tag);
    clear_logs();
    gap_mode = gap;
    fetch_lat = gap ? int'($urandom_range(1, 6)) : 0;
    set_directed();
    push_operands();
    for (int i = 0; i < NC; i++) exp_q.push_back((2*DW)'(dir_exp[i]));
    wait_mlast(1, tag);
    check_pulse_timing(tag);
    drain_and_compare(tag);
    gap_mode = 1'b0;
  endtask

  task automatic test_rand_ready();
    clear_logs();
    rand_ready = 1'b1;
    fetch_lat = int'($urandom_range(0, 6));
    set_random();
    push_operands();
    push_expected_product();
    wait_mlast(1, "rand_ready");
    total_cnt++;
    if (stall_bad !== 0) $display("FAIL rand_ready_stall: unstable stalls %0d, required 0", stall_bad);
    else pass_cnt++;
    check_pulse_timing("rand_ready");
    drain_and_compare("rand_ready");
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int budget;
    clear_logs();
    fetch_lat = 2;
    set_random();
    push_operands();
    budget = 500;
    while (got_q.size() < 2 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    total_cnt++;
    if (got_q.size() !== 2 || m_valid !== 1'b1)
      $display("FAIL rst_drain_reach: got %0d results m_valid=%b, required 2 1", got_q.size(), m_valid);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({s_ready, m_valid, m_last, load_params, start_comp, busy, timeout_err} !== 7'b0 ||
        m_data !== '0 || input_data_a !== '0)
      $display("FAIL rst_drain_outputs: got ctrl=%b m_data=%h, required 0",
               {s_ready, m_valid, m_last, load_params, start_comp, busy, timeout_err}, m_data);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (s_ready !== 1'b1 || got_q.size() !== 2)
      $display("FAIL rst_drain_release: got s_ready=%b results=%0d, required 1 2", s_ready, got_q.size());
    else pass_cnt++;
    clear_logs();
    set_random();
    push_operands();
    push_expected_product();
    wait_mlast(1, "rst_fresh");
    drain_and_compare("rst_fresh");
  endtask

  task automatic test_back_to_back();
    clear_logs();
    fetch_lat = 1;
    set_random();
    push_operands();
    push_expected_product();
    set_random();
    push_operands();
    push_expected_product();
    wait_mlast(2, "b2b");
    total_cnt++;
    if (acc_cyc_q.size() !== 2 * NB || acc_cyc_q[NB] !== mlast_q[0] + 1)
      $display("FAIL b2b_second_accept: beat %0d at cycle %0d (beats %0d), required cycle %0d",
               NB, acc_cyc_q[NB], acc_cyc_q.size(), mlast_q[0] + 1);
    else pass_cnt++;
    drain_and_compare("b2b");
  endtask

`ifdef SYS_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int budget;
    clear_logs();
    fetch_hold = 1'b1;
    set_random();
    push_operands();
    budget = 400;
    while (to_q.size() == 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (to_q.size() !== 1 || to_q[0] !== lastw_q[0] + 3 + TO)
      $display("FAIL timeout_cycle: set at %0d (count %0d), required %0d", to_q[0], to_q.size(), lastw_q[0] + 3 + TO);
    else pass_cnt++;
    total_cnt++;
    if (mv_q.size() !== 0 || to_sready !== 1'b1)
      $display("FAIL timeout_outputs: m_valid rises %0d s_ready=%b, required 0 1", mv_q.size(), to_sready);
    else pass_cnt++;
    total_cnt++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b, required 1", timeout_err);
    else pass_cnt++;
    fetch_hold = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clear: got %b, required 0", timeout_err);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_directed(1'b0, "directed");
    test_directed(1'b1, "gap");
    test_rand_ready();
    test_reset_mid_drain();
    test_back_to_back();
`ifdef SYS_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
